// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   AW, DW : default address / word widths of the external memory port
//   grant_t: which source owns the memory port in the current cycle
package mem_arb_pkg;
  localparam int AW = 8;
  localparam int DW = 15;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } grant_t;
endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating wait counter for a pending debug request.
//   ph1/ph2 : two-phase clock; next value captured at ph2, visible at ph1
//   reset   : synchronous active-high, sampled at ph2
//   clr     : force count to zero (wins over inc)
//   inc     : count up by one, holding at MAXWAIT
//   sat     : count currently equals MAXWAIT
module arb_wait_ctr #(
  parameter int WCW     = 3,
  parameter int MAXWAIT = 4
) (
  input  logic ph1,
  input  logic ph2,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam logic [WCW-1:0] MAXV = WCW'(MAXWAIT);

  logic [WCW-1:0] cnt_d, cnt_m_q, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != MAXV) cnt_d = cnt_q + 1'b1;
  end

  // ph2 stage samples next state (and reset); ph1 stage publishes it
  always_ff @(posedge ph2) begin
    if (reset) cnt_m_q <= '0;
    else       cnt_m_q <= cnt_d;
  end

  always_ff @(posedge ph1) cnt_q <= cnt_m_q;

  assign sat = (cnt_q == MAXV);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between the core and a debug/loader port.
//   ph1/ph2, reset        : two-phase clock, synchronous active-high reset
//   cpu_*                 : core request/lock/write/address/data, cpu_stall back
//   dbg_*                 : debug request/write/address/data, ack + read data back
//   dbg_halt / halted     : level halt request and halted status
//   mem_*                 : external memory port (async read data in)
// Grant is combinational from inputs plus registered halted / wait count.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = mem_arb_pkg::AW,
  parameter int DW      = mem_arb_pkg::DW,
  parameter int MAXWAIT = 4,
  parameter int WCW     = 3
) (
  input  logic          ph1,
  input  logic          ph2,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_lock,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_halt,
  output logic          halted,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  grant_t gnt;
  logic   wait_sat;
  logic   halted_d, halted_m_q, halted_q;

  // Lock first so a two-cycle instruction is never split; while halted the
  // core never touches the port, so an idle halted cycle grants nobody.
  always_comb begin
    gnt = GNT_NONE;
    if (reset)                             gnt = GNT_CPU;
    else if (cpu_lock)                     gnt = GNT_CPU;
    else if (halted_q)                     gnt = dbg_req ? GNT_DBG : GNT_NONE;
    else if (dbg_req && (!cpu_req || wait_sat)) gnt = GNT_DBG;
    else if (cpu_req)                      gnt = GNT_CPU;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = cpu_adr;
    mem_wdata = cpu_wdata;
    case (gnt)
      GNT_DBG: begin
        mem_we    = dbg_we;
        mem_adr   = dbg_adr;
        mem_wdata = dbg_wdata;
      end
      GNT_CPU: mem_we = cpu_we & ~reset;
      default: ;
    endcase
  end

  assign dbg_ack   = (gnt == GNT_DBG);
  assign dbg_rdata = mem_rdata;
  // halted_q is stale during the reset cycle, so reset masks it here
  assign cpu_stall = ~reset & ((cpu_req & (gnt != GNT_CPU)) | halted_q);
  assign halted    = halted_q;

  // Halt entry is deferred while the core holds the lock.
  always_comb begin
    halted_d = halted_q;
    if (!dbg_halt)                   halted_d = 1'b0;
    else if (!halted_q && !cpu_lock) halted_d = 1'b1;
  end

  always_ff @(posedge ph2) begin
    if (reset) halted_m_q <= 1'b0;
    else       halted_m_q <= halted_d;
  end

  always_ff @(posedge ph1) halted_q <= halted_m_q;

  arb_wait_ctr #(.WCW(WCW), .MAXWAIT(MAXWAIT)) u_wait (
    .ph1   (ph1),
    .ph2   (ph2),
    .reset (reset),
    .clr   ((gnt == GNT_DBG) | ~dbg_req),
    .inc   (dbg_req & (gnt != GNT_DBG)),
    .sat   (wait_sat)
  );
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (Adr, 15-bit instruction/data word, MemWrite) between the processor core and a debug/loader port.
- The loader port uses it for program load, memory inspection and patching while the core runs or is halted.
- Sits in top between controller/datapath and the pads; the core sees a stall when it loses the port.
- Enforces: no split of a two-cycle instruction, CPU-first priority, bounded debug wait, explicit core halt.

Parameters:
- AW, 8, address width.
- DW, 15, memory word width (Instr[14:8] concatenated with MemData[7:0]).
- MAXWAIT, 4, cycles a pending debug request may be denied before forced grant; legal range 1..7 (1 = strict alternation).
- WCW, 3, wait counter width; must satisfy 2^WCW > MAXWAIT.

Ports:
- ph1  in  1  phase 1 of the single two-phase non-overlapping clock; registers update at ph1.
- ph2  in  1  phase 2 of the same clock; next-state sampled during ph2.
- reset  in  1  synchronous, active-high; sampled during ph2.
- cpu_req  in  1  core wants the port this cycle.
- cpu_lock  in  1  core is in second cycle of a two-cycle instruction (controller state=1); port must stay with core.
- cpu_we  in  1  core write enable.
- cpu_adr  in  AW  core address.
- cpu_wdata  in  DW  core write data.
- cpu_stall  out  1  core must hold PC/state this cycle.
- dbg_req  in  1  debug access request; held until dbg_ack.
- dbg_we  in  1  debug write enable.
- dbg_adr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  debug access performed this cycle.
- dbg_rdata  out  DW  read data, valid when dbg_ack & ~dbg_we.
- dbg_halt  in  1  level request to halt the core.
- halted  out  1  core is halted; debug owns port.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wdata  out  DW  memory write data (top drives tristate).
- mem_rdata  in  DW  memory read data (asynchronous read, same cycle).

Behaviour:
- Clocking: one clock domain using the codebase's two-phase scheme. State registers: halted, wait_cnt[WCW-1:0]. Grant is combinational from inputs and registered state.
- Reset cycle:
  - Grant goes to the core; mem_we=0; cpu_stall=0; dbg_ack=0.
  - The core's first fetch is therefore not blocked.
  - Registers clear next cycle: halted=0, wait_cnt=0.
  - A reset arriving mid-debug-access aborts it without ack; the requester must retry.
- Grant priority per non-reset cycle, first match wins:
  1. cpu_lock=1: grant core.
  2. halted=1: grant debug if dbg_req.
  3. dbg_req & (~cpu_req | wait_cnt==MAXWAIT): grant debug.
  4. cpu_req: grant core.
  5. Otherwise idle: mem_we=0, mem_adr=cpu_adr.
- Outputs:
  - mem_* mux from the granted source; mem_we is gated by that source's we.
  - dbg_ack = debug granted; dbg_rdata = mem_rdata.
  - cpu_stall = (cpu_req & ~core granted) | halted.
  - halted forces stall even if cpu_lock is asserted by a stale controller state. Halt entry waits for cpu_lock=0, so this cannot occur legally.
- wait_cnt:
  - Resets to 0 when debug is granted or dbg_req=0.
  - Increments, saturating at MAXWAIT, when dbg_req & ~debug granted.
  - After a forced grant the count restarts, so the core gets at least one cycle before the next forced grant.
- halted:
  - Sets at cycle end when dbg_halt & ~cpu_lock & ~halted.
  - Clears at cycle end when ~dbg_halt.
  - A halt request during cpu_lock is deferred until the lock drops.
  - Simultaneous dbg_halt deassert and dbg_req: the request is still served in that cycle under halted rules.
- Debug handshake: one access per ack. Requester must drop dbg_req or change address the cycle after ack; a still-high dbg_req is a new request.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef grant_t {GNT_NONE, GNT_CPU, GNT_DBG};
  - constants AW=8, DW=15.
- One natural sub-module, arb_wait_ctr: saturating counter with clear/increment/saturate-compare. Everything else is inline in mem_port_arbiter.

Test Plan:
- Reset high with cpu_req=1, cpu_adr=0x00, dbg_req=1 → mem_adr=0x00, mem_we=0, cpu_stall=0, dbg_ack=0; after release halted=0.
- cpu_req=0, dbg_req=1, dbg_we=1, dbg_adr=0x20, dbg_wdata=0x1ABC → same cycle mem_we=1, mem_adr=0x20, mem_wdata=0x1ABC, dbg_ack=1.
- cpu_req held 1 and dbg_req held 1 for 12 cycles, MAXWAIT=4 → dbg_ack in cycles 5 and 10 only; cpu_stall=1 exactly in those cycles.
- cpu_lock=1 with wait_cnt=4 and dbg_req=1 → core granted; debug granted the first cycle cpu_lock=0.
- dbg_halt=1 raised while cpu_lock=1 → halted stays 0 until the cycle after lock drops, then halted=1 and cpu_stall=1. Debug read of 0x05 holding 0x7F00 → dbg_rdata=0x7F00 with dbg_ack=1.
- Reset asserted during a debug write cycle → mem_we=0, dbg_ack=0, halted=0 and wait_cnt=0 next cycle.
